// File: rtl/countdown_display.sv
// Two-digit multiplexed 7-segment display for a mod-25 down-counter,
// with wrap pulse, post-wrap blink sequence and sticky out-of-range error.
module countdown_display #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_LEN = 8
) (
  input  logic       ck,
  input  logic       rs,
  input  logic [4:0] cnt,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap,
  output logic       err
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_LEN - 1);
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_BLINK_OFF = 2'd1,
    ST_BLINK_ON  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  logic [4:0]    cur_q;
  logic [DW-1:0] div_q, div_d;
  logic          sel_q, sel_d;
  logic [FW-1:0] frm_q, frm_d;
  state_t        state_q, state_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          wrap_q;
  logic          err_q;

  logic          wrap_s;
  logic          err_s;
  logic          frame_end_s;
  logic          restart_s;
  logic [1:0]    tens_s;
  logic [4:0]    ones_full_s;
  logic [3:0]    ones_s;

  assign wrap_s      = (cur_q == 5'd0) && (cnt == 5'd24);
  assign err_s       = err_q || (cnt > 5'd24);
  assign frame_end_s = sel_q && (div_q == DIV_MAX);
  // A wrap only restarts the blink/scan when no error is (or is becoming) latched.
  assign restart_s   = wrap_s && !err_s;

  // BCD split of the registered count
  always_comb begin
    tens_s      = 2'd0;
    ones_full_s = cur_q;
    if (cur_q >= 5'd20) begin
      tens_s      = 2'd2;
      ones_full_s = cur_q - 5'd20;
    end else if (cur_q >= 5'd10) begin
      tens_s      = 2'd1;
      ones_full_s = cur_q - 5'd10;
    end else begin
      tens_s      = 2'd0;
      ones_full_s = cur_q;
    end
    ones_s = ones_full_s[3:0];
  end

  // Scan divider and digit select; a wrap restart realigns the scan
  always_comb begin
    div_d = div_q;
    sel_d = sel_q;
    if (restart_s) begin
      div_d = '0;
      sel_d = 1'b0;
    end else if (div_q == DIV_MAX) begin
      div_d = '0;
      sel_d = ~sel_q;
    end else begin
      div_d = div_q + DW'(1);
      sel_d = sel_q;
    end
  end

  // Blink FSM next state; error beats wrap, wrap beats frame end
  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    if (err_s) begin
      state_d = ST_NORMAL;
      frm_d   = '0;
    end else if (wrap_s) begin
      state_d = ST_BLINK_OFF;
      frm_d   = '0;
    end else if ((state_q != ST_NORMAL) && frame_end_s) begin
      if (frm_q == FRM_MAX) begin
        state_d = ST_NORMAL;
        frm_d   = '0;
      end else begin
        state_d = (state_q == ST_BLINK_OFF) ? ST_BLINK_ON : ST_BLINK_OFF;
        frm_d   = frm_q + FW'(1);
      end
    end else begin
      state_d = state_q;
      frm_d   = frm_q;
    end
  end

  // Display output decode from current count, digit select and state
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 2'b00;
    if (state_q == ST_BLINK_OFF) begin
      seg_d = SEG_BLANK;
      an_d  = 2'b00;
    end else if (sel_q) begin
      an_d = 2'b10;
      if (err_q) begin
        seg_d = SEG_DASH;
      end else if (tens_s == 2'd0) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = seg_code({2'b00, tens_s});
      end
    end else begin
      an_d = 2'b01;
      if (err_q) begin
        seg_d = SEG_DASH;
      end else begin
        seg_d = seg_code(ones_s);
      end
    end
  end

  // State and output registers
  always_ff @(posedge ck) begin
    if (rs) begin
      cur_q   <= 5'd24;
      div_q   <= '0;
      sel_q   <= 1'b0;
      frm_q   <= '0;
      state_q <= ST_NORMAL;
      seg_q   <= SEG_BLANK;
      an_q    <= 2'b00;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cur_q   <= cnt;
      div_q   <= div_d;
      sel_q   <= sel_d;
      frm_q   <= frm_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      wrap_q  <= wrap_s;
      err_q   <= err_s;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: directed test-plan sequences then a randomized
// down-counter walk, all checked every cycle against a time-based reference model.
module tb_countdown_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_LEN = 8;
  localparam int FRAME     = 2 * SCAN_DIV;

  logic       ck  = 1'b0;
  logic       rs  = 1'b1;
  logic [4:0] cnt = 5'd13;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic       err;

  countdown_display #(.SCAN_DIV(SCAN_DIV), .BLINK_LEN(BLINK_LEN)) dut (
    .ck   (ck),
    .rs   (rs),
    .cnt  (cnt),
    .seg  (seg),
    .an   (an),
    .wrap (wrap),
    .err  (err)
  );

  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail  = 0;

  int seg_tab [10] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66,
                       32'h6D, 32'h7D, 32'h07, 32'h7F, 32'h6F};

  // Reference model: scan phase and blink phase come from elapsed cycle counts.
  int cyc     = 0;
  int cur_m   = 24;
  bit err_m   = 1'b0;
  int origin  = 0;
  bit blink_m = 1'b0;
  int bstart  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int c, input bit r);
    int p;
    int fr;
    bit sel;
    bit off;
    int exp_seg;
    int exp_an;
    int exp_wrap;
    int exp_err;
    @(negedge ck);
    cnt = c[4:0];
    rs  = r;
    @(posedge ck);
    if (r) begin
      exp_seg = 0; exp_an = 0; exp_wrap = 0; exp_err = 0;
      cur_m   = 24;
      err_m   = 1'b0;
      origin  = cyc + 1;
      blink_m = 1'b0;
    end else begin
      p   = (cyc - origin) % FRAME;
      sel = (p >= SCAN_DIV);
      off = 1'b0;
      if (blink_m) begin
        fr = (cyc - bstart) / FRAME;
        if (fr >= BLINK_LEN) blink_m = 1'b0;
        else off = ((fr % 2) == 0);
      end
      if (off) begin
        exp_an = 0; exp_seg = 0;
      end else if (sel) begin
        exp_an  = 2;
        exp_seg = err_m ? 32'h40 : ((cur_m / 10 == 0) ? 0 : seg_tab[cur_m / 10]);
      end else begin
        exp_an  = 1;
        exp_seg = err_m ? 32'h40 : seg_tab[cur_m % 10];
      end
      exp_wrap = (cur_m == 0 && c == 24) ? 1 : 0;
      exp_err  = (err_m || c > 24) ? 1 : 0;
      if (exp_err != 0) begin
        blink_m = 1'b0;
      end else if (exp_wrap != 0) begin
        blink_m = 1'b1;
        bstart  = cyc + 1;
        origin  = cyc + 1;
      end
      err_m = (exp_err != 0);
      cur_m = c;
    end
    cyc++;
    #1;
    check_val("seg",  {25'd0, seg},  exp_seg);
    check_val("an",   {30'd0, an},   exp_an);
    check_val("wrap", {31'd0, wrap}, exp_wrap);
    check_val("err",  {31'd0, err},  exp_err);
  endtask

  initial begin
    int v;
    int c;
    int k;
    bit r;
    // reset, scan, leading-zero blank
    repeat (2) step(13, 1'b1);
    repeat (20) step(17, 1'b0);
    repeat (10) step(5, 1'b0);
    // wrap and full blink sequence, then non-wrap cases
    step(1, 1'b0); step(0, 1'b0);
    repeat (75) step(24, 1'b0);
    repeat (6) step(0, 1'b0);
    step(3, 1'b0);
    repeat (5) step(24, 1'b0);
    // wrap restart around frame 5
    step(1, 1'b0); step(0, 1'b0);
    repeat (44) step(24, 1'b0);
    step(0, 1'b0);
    repeat (75) step(24, 1'b0);
    // sticky error, wrap while in error, release by reset
    step(27, 1'b0);
    repeat (20) step(10, 1'b0);
    step(0, 1'b0);
    repeat (10) step(24, 1'b0);
    step(10, 1'b1);
    // reset mid-blink
    step(0, 1'b0);
    repeat (20) step(24, 1'b0);
    step(24, 1'b1);
    repeat (10) step(24, 1'b0);
    // randomized down-counter walk with jumps, illegal values and resets
    v = 24;
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 199);
      r = ($urandom_range(0, 149) == 0);
      if (k < 120) v = (v == 0) ? 24 : v - 1;
      else if (k < 170) v = v;
      else if (k < 197) v = $urandom_range(0, 24);
      else v = v;
      c = v;
      if (k >= 197 && k < 199) c = $urandom_range(25, 31);
      step(c, r);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
